// File: rtl/dbg_pkg.sv
// rtl/dbg_pkg.sv - shared state encoding and default widths for the debug peek arbiter
//
// Purpose: common definitions imported by dbg_peek_arbiter and scan_stepper.
// Ports:   none (package).
package dbg_pkg;

  localparam int DBG_ADDR_W = 9;
  localparam int DBG_DATA_W = 32;

  // IDLE: no debug request pending; WAIT: pending and denied at least once;
  // CAPTURE: debug read data returning from the memory this cycle.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_CAPTURE = 2'd2
  } dbg_state_t;

endpackage

// File: rtl/scan_stepper.sv
// rtl/scan_stepper.sv - auto-scan timer that walks the debug peek address
//
// Purpose: detects the scanEn rising edge, runs the scan timer and steps the
//          scan address once per SCAN_PERIOD cycles; selects the peek address.
// Ports:   Clk, Rst (async active-low)
//          scanEn  - auto-scan mode level
//          dbgAddr - manual peek address (switches), also the scan start point
//          effAddr - effective peek address presented to the arbiter
module scan_stepper
  import dbg_pkg::*;
#(
  parameter int ADDR_W      = DBG_ADDR_W,
  parameter int SCAN_PERIOD = 50000000
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              scanEn,
  input  logic [ADDR_W-1:0] dbgAddr,
  output logic [ADDR_W-1:0] effAddr
);

  localparam int TIMER_W = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(SCAN_PERIOD - 1);

  logic               scanEnQ;
  logic               scanRise;
  logic [TIMER_W-1:0] scanTimer;
  logic [ADDR_W-1:0]  scanAddr;

  assign scanRise = scanEn & ~scanEnQ;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      scanEnQ   <= 1'b0;
      scanTimer <= '0;
      scanAddr  <= '0;
    end else begin
      scanEnQ <= scanEn;
      if (scanRise) begin
        scanAddr  <= dbgAddr;
        scanTimer <= '0;
      end else if (scanEn) begin
        if (scanTimer == TIMER_LAST) begin
          scanTimer <= '0;
          scanAddr  <= scanAddr + ADDR_W'(1);
        end else begin
          scanTimer <= scanTimer + TIMER_W'(1);
        end
      end else begin
        scanTimer <= '0;
      end
    end
  end

  // In the edge cycle scanAddr still holds the previous walk; the start point
  // being loaded is dbgAddr, so present that directly.
  assign effAddr = (!scanEn || scanRise) ? dbgAddr : scanAddr;

endmodule

// File: rtl/dbg_peek_arbiter.sv
// rtl/dbg_peek_arbiter.sv - shares the data-memory read port between CPU loads and debug peeks
//
// Purpose: CPU has priority on the read port; a starvation counter forces a
//          debug slot after STARVE_LIMIT denials. Captured peek data is held
//          in registers for the display logic.
// Ports:   Clk, Rst (async active-low)
//          cpuMemRd, cpuMemAddr, cpuStall   - CPU load path
//          memRdEn, memAddr, memRdData      - memory read port (1-cycle latency)
//          dbgEn, dbgAddr, scanEn           - debugger controls
//          dbgData, dbgAddrShown, dbgValid  - registered peek result
module dbg_peek_arbiter
  import dbg_pkg::*;
#(
  parameter int ADDR_W       = DBG_ADDR_W,
  parameter int DATA_W       = DBG_DATA_W,
  parameter int STARVE_LIMIT = 8,
  parameter int SCAN_PERIOD  = 50000000
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              cpuMemRd,
  input  logic [31:0]       cpuMemAddr,
  output logic              cpuStall,
  output logic              memRdEn,
  output logic [31:0]       memAddr,
  input  logic [DATA_W-1:0] memRdData,
  input  logic              dbgEn,
  input  logic [ADDR_W-1:0] dbgAddr,
  input  logic              scanEn,
  output logic [DATA_W-1:0] dbgData,
  output logic [ADDR_W-1:0] dbgAddrShown,
  output logic              dbgValid
);

  localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  dbg_state_t        state, stateNext;
  logic [CNT_W-1:0]  starveCnt, starveCntNext;
  logic [ADDR_W-1:0] effAddr;
  logic [ADDR_W-1:0] pendAddr;
  logic              contend;
  logic              forced;
  logic              grant;

  scan_stepper #(
    .ADDR_W      (ADDR_W),
    .SCAN_PERIOD (SCAN_PERIOD)
  ) u_scan (
    .Clk     (Clk),
    .Rst     (Rst),
    .scanEn  (scanEn),
    .dbgAddr (dbgAddr),
    .effAddr (effAddr)
  );

  // Rst gates the grant so the port is a plain CPU pass-through while reset is held.
  assign contend = Rst && dbgEn && (state != ST_CAPTURE);
  assign forced  = (state == ST_WAIT) && (starveCnt == CNT_MAX);
  assign grant   = contend && (!cpuMemRd || forced);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state     <= ST_IDLE;
      starveCnt <= '0;
    end else begin
      state     <= stateNext;
      starveCnt <= starveCntNext;
    end
  end

  always_comb begin
    stateNext     = state;
    starveCntNext = starveCnt;
    cpuStall      = 1'b0;
    memRdEn       = cpuMemRd;
    memAddr       = cpuMemAddr;

    case (state)
      ST_IDLE, ST_WAIT: begin
        if (grant) begin
          stateNext     = ST_CAPTURE;
          starveCntNext = '0;
        end else if (dbgEn) begin
          stateNext     = ST_WAIT;
          starveCntNext = (starveCnt == CNT_MAX) ? starveCnt : starveCnt + CNT_W'(1);
        end else begin
          stateNext     = ST_IDLE;
          starveCntNext = '0;
        end
      end
      ST_CAPTURE: begin
        // Port stays with the CPU while debug data returns.
        stateNext     = dbgEn ? ST_WAIT : ST_IDLE;
        starveCntNext = '0;
      end
      default: begin
        stateNext     = ST_IDLE;
        starveCntNext = '0;
      end
    endcase

    if (grant) begin
      memRdEn  = 1'b1;
      memAddr  = 32'(effAddr);
      cpuStall = cpuMemRd;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      pendAddr     <= '0;
      dbgData      <= '0;
      dbgAddrShown <= '0;
      dbgValid     <= 1'b0;
    end else begin
      dbgValid <= (state == ST_CAPTURE);
      if (grant) begin
        pendAddr <= effAddr;
      end
      if (state == ST_CAPTURE) begin
        dbgData      <= memRdData;
        dbgAddrShown <= pendAddr;
      end
    end
  end

endmodule

// File: doc/dbg_peek_arbiter.md
# dbg_peek_arbiter

Shares the single synchronous data-memory read port between the processor load path and the debugger peek path. The CPU has priority, and a starvation counter guarantees the debugger a slot. The block continuously refreshes a registered, stable peek value for the seven-segment display logic. It also provides an auto-scan mode that steps the peek address on a timer, so memory can be walked without toggling switches.

## Interface
- ADDR_W, 9: debugger peek address width (word index).
- DATA_W, 32: memory data width.
- STARVE_LIMIT, 8: consecutive denied cycles before the debugger is force-granted.
- SCAN_PERIOD, 50000000: cycles per auto-scan address step.

- Clk  in  1  clock; all state updates on posedge.
- Rst  in  1  asynchronous, active-low reset.
- cpuMemRd  in  1  CPU read request for this cycle; held by the CPU while stalled.
- cpuMemAddr  in  32  CPU read address.
- cpuStall  out  1  CPU read not accepted this cycle.
- memRdEn  out  1  read enable to the memory port.
- memAddr  out  32  address to the memory port.
- memRdData  in  DATA_W  memory read data, valid one cycle after memRdEn.
- dbgEn  in  1  debugger peek active (level).
- dbgAddr  in  ADDR_W  manual peek address (switches).
- scanEn  in  1  auto-scan mode (level).
- dbgData  out  DATA_W  last captured peek value (registered).
- dbgAddrShown  out  ADDR_W  address that dbgData belongs to (registered).
- dbgValid  out  1  one-cycle pulse: dbgData updated this cycle.

## Operation
- States: IDLE (no debug request pending), WAIT (pending, denied at least once), CAPTURE (debug read data returning).
- Effective peek address effAddr = scanEn ? scanAddr : dbgAddr.
- Grant condition (IDLE or WAIT, with dbgEn=1):
  - Grant if cpuMemRd=0, or if state=WAIT and starveCnt==STARVE_LIMIT.
  - On grant: memRdEn=1, memAddr={zeros, effAddr}, effAddr registered into a pending-address register, starveCnt cleared, next state CAPTURE.
  - cpuStall=cpuMemRd in a grant cycle. cpuStall=0 in all other cycles.
- No grant: memRdEn=cpuMemRd, memAddr=cpuMemAddr. Port mux and cpuStall are combinational.
- Denial (dbgEn=1 and cpuMemRd=1 with no forced grant): next state WAIT, starveCnt+1. The counter saturates at STARVE_LIMIT.
- In WAIT with dbgEn=0: next state IDLE, starveCnt cleared.
- CAPTURE:
  - The port belongs to the CPU this cycle.
  - At the closing edge, dbgData<=memRdData, dbgAddrShown<=pending address, dbgValid<=1.
  - Next state WAIT if dbgEn=1 (continuous refresh), else IDLE.
  - A capture in progress always completes, even if dbgEn drops.
- Auto-scan:
  - On scanEn rising edge (registered previous value), scanAddr<=dbgAddr and scanTimer<=0.
  - While scanEn=1, scanTimer counts 0..SCAN_PERIOD-1. On wrap, scanAddr increments, with 2^ADDR_W-1 wrapping to 0.
  - scanEn=0 clears scanTimer.
- Reset (asynchronous, any state, including mid-CAPTURE):
  - state=IDLE; starveCnt, scanAddr, scanTimer cleared.
  - dbgData=0, dbgAddrShown=0, dbgValid=0.
  - While reset is held: cpuStall=0, memRdEn=cpuMemRd, memAddr=cpuMemAddr.

## Timing
- Debug read latency: grant in cycle t; data captured at end of t+1; dbgData/dbgValid visible in t+2.
- Refresh cadence with an idle CPU is one grant every 2 cycles. Each capture is followed by a WAIT cycle in which a grant can occur.
- Worst-case debug wait with a saturated CPU is STARVE_LIMIT+1 cycles from request to grant. The CPU loses at most 1 cycle per STARVE_LIMIT+2.
- Simultaneous requests with starveCnt<STARVE_LIMIT: the CPU wins.
- A scan step and a grant in the same cycle: the grant uses the pre-step scanAddr.

## Structure
- Package dbg_pkg: state encoding (IDLE, WAIT, CAPTURE) and the default widths ADDR_W and DATA_W.
- Sub-module scan_stepper: scanEn edge detect, scanTimer, scanAddr. Outputs effAddr.
- Top: FSM, starve counter, port mux, capture registers.

## Test plan
Bench parameters: STARVE_LIMIT=4, SCAN_PERIOD=8.
- Idle CPU: dbgEn=1, dbgAddr=0x005, mem[5]=0xDEADBEEF -> memRdEn=1, memAddr=0x5 in cycle t; dbgValid=1, dbgData=0xDEADBEEF, dbgAddrShown=0x005 in t+2; next grant at t+2.
- Starvation: cpuMemRd held 1, dbgEn=1 -> 4 denial cycles with cpuStall=0, then a grant cycle with cpuStall=1, memAddr=dbgAddr, then normal CPU service.
- Collision: cpuMemRd=1, cpuMemAddr=0x40, dbgEn rises -> memAddr=0x40, cpuStall=0, state WAIT, starveCnt=1.
- Scan: dbgAddr=0x1FE, scanEn rises, CPU idle -> grants on 0x1FE, then 0x1FF after 8 cycles, then 0x000 after 16 cycles (wrap).
- dbgEn drops in WAIT at starveCnt=3 -> IDLE, starveCnt=0; dbgEn re-raised with CPU busy -> 4 fresh denials before the forced grant.
- Rst low during CAPTURE -> dbgValid=0, dbgData=0 immediately, no capture pulse; after release with dbgEn=1 and CPU idle -> grant in the first active cycle.
